// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, bit positions
// and the controller redirect payload.
package cp0_defs;

   localparam int unsigned XLEN           = 32;
   localparam int unsigned CP0_ADDR_W     = 8;
   localparam int unsigned CP0_TO_CTRL_WD = 33;

   // {rd[4:0], sel[2:0]}
   localparam logic [CP0_ADDR_W-1:0] CP0_BADVADDR = {5'd8,  3'd0};
   localparam logic [CP0_ADDR_W-1:0] CP0_COUNT    = {5'd9,  3'd0};
   localparam logic [CP0_ADDR_W-1:0] CP0_COMPARE  = {5'd11, 3'd0};
   localparam logic [CP0_ADDR_W-1:0] CP0_STATUS   = {5'd12, 3'd0};
   localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE    = {5'd13, 3'd0};
   localparam logic [CP0_ADDR_W-1:0] CP0_EPC      = {5'd14, 3'd0};

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
   localparam logic [XLEN-1:0] STATUS_RST_DEF = 32'h0040_0000;

   localparam int unsigned ST_IE   = 0;
   localparam int unsigned ST_EXL  = 1;
   localparam int unsigned ST_BEV  = 22;
   localparam int unsigned IM_LO   = 8;
   localparam int unsigned IM_HI   = 15;
   localparam int unsigned IP_LO   = 8;
   localparam int unsigned IP_HI   = 15;
   localparam int unsigned EXC_LO  = 2;
   localparam int unsigned EXC_HI  = 6;
   localparam int unsigned CA_BD   = 31;

   localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;

   typedef struct packed {
      logic            flush;
      logic [XLEN-1:0] new_pc;
   } cp0_ctrl_t;

endpackage

// File: rtl/cp0_unit_if.sv
// MEM-stage exception/mtc0/mfc0 bundle between the pipeline and CP0.
interface cp0_unit_if;
   import cp0_defs::*;

   logic [5:0]                ext_int;
   logic                      inst_valid;
   logic [XLEN-1:0]           pc;
   logic                      in_delayslot;
   logic [XLEN-1:0]           bad_vaddr;
   logic                      excp_adel_if;
   logic                      excp_ri;
   logic                      excp_ov;
   logic                      excp_syscall;
   logic                      excp_break;
   logic                      excp_adel;
   logic                      excp_ades;
   logic                      excp_eret;
   logic                      we;
   logic [CP0_ADDR_W-1:0]     waddr;
   logic [XLEN-1:0]           wdata;
   logic [CP0_ADDR_W-1:0]     raddr;
   logic [XLEN-1:0]           rdata;
   logic [CP0_TO_CTRL_WD-1:0] CP0_to_ctrl_bus;
   logic                      stallreq_for_cp0;

   modport master (
      output ext_int, inst_valid, pc, in_delayslot, bad_vaddr,
             excp_adel_if, excp_ri, excp_ov, excp_syscall, excp_break,
             excp_adel, excp_ades, excp_eret, we, waddr, wdata, raddr,
      input  rdata, CP0_to_ctrl_bus, stallreq_for_cp0
   );

   modport slave (
      input  ext_int, inst_valid, pc, in_delayslot, bad_vaddr,
             excp_adel_if, excp_ri, excp_ov, excp_syscall, excp_break,
             excp_adel, excp_ades, excp_eret, we, waddr, wdata, raddr,
      output rdata, CP0_to_ctrl_bus, stallreq_for_cp0
   );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other cycle, TI is a sticky match flag.
module cp0_timer
   import cp0_defs::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            count_we,
   input  logic            compare_we,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] count,
   output logic [XLEN-1:0] compare,
   output logic            ti
);

   logic            tick;
   logic            count_upd;
   logic [XLEN-1:0] count_nxt;
   logic [XLEN-1:0] compare_nxt;
   logic            ti_nxt;

   // A match is only taken when Count moves, so the reset-time 0==0 does not fire
   always_comb begin
      count_upd   = tick | count_we;
      count_nxt   = count;
      compare_nxt = compare;
      if (count_we)
         count_nxt = wdata;
      else if (tick)
         count_nxt = count + 32'd1;
      if (compare_we)
         compare_nxt = wdata;
      ti_nxt = compare_we ? 1'b0 : (ti | (count_upd & (count_nxt == compare_nxt)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick    <= 1'b0;
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         tick    <= ~tick;
         count   <= count_nxt;
         compare <= compare_nxt;
         ti      <= ti_nxt;
      end
   end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: exception/interrupt arbitration, CP0 register file and
// the flush/redirect request to the pipeline controller.
module cp0_unit
   import cp0_defs::*;
#(
   parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
   parameter logic [XLEN-1:0] STATUS_RST = STATUS_RST_DEF
)(
   input  logic       clk,
   input  logic       rst,
   cp0_unit_if.slave  cp0
);

   logic [XLEN-1:0] status_q, cause_q, epc_q, badvaddr_q;
   logic [XLEN-1:0] count, compare;
   logic            ti;
   logic            stall_q;

   logic            pending, any_excp, exc_take, eret_take, trap, mtc0_ok;
   logic [4:0]      exc_code;
   cp0_ctrl_t       ctrl;

   // Trap arbitration; interrupt outranks every synchronous exception, ERET is last
   always_comb begin
      pending   = status_q[ST_IE] & ~status_q[ST_EXL]
                  & (|(cause_q[IP_HI:IP_LO] & status_q[IM_HI:IM_LO]));
      any_excp  = cp0.excp_adel_if | cp0.excp_ri | cp0.excp_ov | cp0.excp_syscall
                  | cp0.excp_break | cp0.excp_adel | cp0.excp_ades;
      exc_take  = cp0.inst_valid & (pending | any_excp);
      eret_take = cp0.inst_valid & cp0.excp_eret & ~exc_take;
      trap      = exc_take | eret_take;
      mtc0_ok   = cp0.we & ~trap;
      exc_code  = EXC_INT;
      if (pending)               exc_code = EXC_INT;
      else if (cp0.excp_adel_if) exc_code = EXC_ADEL;
      else if (cp0.excp_ri)      exc_code = EXC_RI;
      else if (cp0.excp_ov)      exc_code = EXC_OV;
      else if (cp0.excp_syscall) exc_code = EXC_SYS;
      else if (cp0.excp_break)   exc_code = EXC_BP;
      else if (cp0.excp_adel)    exc_code = EXC_ADEL;
      else if (cp0.excp_ades)    exc_code = EXC_ADES;
   end

   // Redirect is same-cycle; reset suppresses it so a trap cannot leak out of reset
   always_comb begin
      ctrl = '0;
      if (!rst && exc_take)
         ctrl = '{flush: 1'b1, new_pc: EXC_VECTOR};
      else if (!rst && eret_take)
         ctrl = '{flush: 1'b1, new_pc: epc_q};
   end

   assign cp0.CP0_to_ctrl_bus  = ctrl;
   assign cp0.stallreq_for_cp0 = stall_q;

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0_ok & (cp0.waddr == CP0_COUNT)),
      .compare_we (mtc0_ok & (cp0.waddr == CP0_COMPARE)),
      .wdata      (cp0.wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q   <= STATUS_RST;
         cause_q    <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
         stall_q    <= 1'b0;
      end else begin
         cause_q[IP_HI:IP_HI-5] <= {cp0.ext_int[5] | ti, cp0.ext_int[4:0]};
         stall_q <= mtc0_ok & ((cp0.waddr == CP0_STATUS) | (cp0.waddr == CP0_CAUSE)
                               | (cp0.waddr == CP0_COMPARE));
         if (exc_take) begin
            cause_q[EXC_HI:EXC_LO] <= exc_code;
            if (!status_q[ST_EXL]) begin
               epc_q          <= cp0.in_delayslot ? cp0.pc - 32'd4 : cp0.pc;
               cause_q[CA_BD] <= cp0.in_delayslot;
            end
            status_q[ST_EXL] <= 1'b1;
            if (exc_code == EXC_ADEL || exc_code == EXC_ADES)
               badvaddr_q <= cp0.bad_vaddr;
         end else if (eret_take) begin
            status_q[ST_EXL] <= 1'b0;
         end else if (mtc0_ok) begin
            case (cp0.waddr)
               CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (cp0.wdata & STATUS_WMASK);
               CP0_CAUSE:  cause_q[IP_LO+1:IP_LO] <= cp0.wdata[IP_LO+1:IP_LO];
               CP0_EPC:    epc_q <= cp0.wdata;
               default:    ;
            endcase
         end
      end
   end

   always_comb begin
      case (cp0.raddr)
         CP0_BADVADDR: cp0.rdata = badvaddr_q;
         CP0_COUNT:    cp0.rdata = count;
         CP0_COMPARE:  cp0.rdata = compare;
         CP0_STATUS:   cp0.rdata = status_q;
         CP0_CAUSE:    cp0.rdata = cause_q;
         CP0_EPC:      cp0.rdata = epc_q;
         default:      cp0.rdata = '0;
      endcase
   end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block for the 5-stage MIPS core; sits directly upstream of the pipeline controller.
- Takes per-instruction exception flags from the MEM stage and mtc0/mfc0 accesses, and owns BadVAddr, Count, Compare, Status, Cause and EPC.
- Drives CP0_to_ctrl_bus: {flush, new_pc} into the controller, which flushes the pipeline and redirects the PC.
- Also drives stallreq_for_cp0 to cover the mtc0 interrupt-visibility hazard.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380: handler entry address.
- STATUS_RST, 32'h0040_0000: Status reset value (BEV=1).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ext_int  in  6  hardware interrupt lines, level-sensitive
- inst_valid  in  1  a real instruction occupies MEM this cycle
- pc  in  32  PC of the MEM instruction
- in_delayslot  in  1  MEM instruction is in a branch delay slot
- bad_vaddr  in  32  faulting address: the fetch PC or the data address
- excp_adel_if, excp_ri, excp_ov, excp_syscall, excp_break, excp_adel, excp_ades, excp_eret  in  1 each  exception and eret flags
- we  in  1  mtc0 write enable
- waddr  in  8  {rd[4:0], sel[2:0]}
- wdata  in  32  mtc0 data
- raddr  in  8  mfc0 address
- rdata  out  32  combinational read data; 0 for unimplemented addresses
- CP0_to_ctrl_bus  out  33  [32]=flush, [31:0]=new_pc
- stallreq_for_cp0  out  1  hazard stall request

Behaviour:
- Reset: Status=STATUS_RST; Cause, EPC, BadVAddr, Count and Compare are 0; tick=0; TI=0; stall flag=0; CP0_to_ctrl_bus=0.
- Register map ({rd,sel}): 8=BadVAddr (read-only), 9=Count, 11=Compare, 12=Status, 13=Cause, 14=EPC.
- Writable bits: Status IM[15:8], EXL[1], IE[0]; Cause IP[1:0]. All other bits are read-only. BEV reads 1.
- Cause.IP[7:2] is registered every cycle from {ext_int[5]|TI, ext_int[4:0]}.
- Interrupt pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Trap condition: inst_valid & (pending | any excp flag).
- Priority, highest first: Int(0), AdEL-if(4), RI(10), Ov(12), Sys(8), Bp(9), AdEL-data(4), AdES(5), ERET.
- Flush is combinational in the same cycle as the trap:
  - exception → bus = {1, EXC_VECTOR}
  - ERET → bus = {1, EPC}
  - otherwise → bus = 0
- State update at the next clk edge on an exception:
  - Cause.ExcCode is set.
  - If Status.EXL was 0: EPC = in_delayslot ? pc-4 : pc; Cause.BD = in_delayslot. If EXL was 1, EPC and BD are unchanged.
  - Status.EXL=1.
  - BadVAddr is written for AdEL/AdES only.
- ERET: Status.EXL=0 at the clk edge.
- A trap in the same cycle as we=1 drops the mtc0 (the faulting instruction does not commit).
- Count:
  - tick toggles every cycle; Count+1 when tick=1 (wraps at 2^32).
  - An mtc0 to Count wins over the increment.
- Timer:
  - TI sets (sticky) when Count==Compare after the update.
  - An mtc0 to Compare clears TI; a clear in the same cycle as a match resolves to cleared.
- stallreq_for_cp0: a 1-cycle pulse in the cycle after a committed mtc0 to Status, Cause or Compare, so interrupt evaluation sees the new value.
- rdata: reads return the current register value. Same-cycle write/read returns the old value; the stall pulse covers that case.
- Reset mid-trap: reset wins and the bus returns to 0 that same edge.

Decomposition:
- Package cp0_defs:
  - register addresses (8-bit {rd,sel})
  - ExcCode constants
  - EXC_VECTOR default
  - CP0_TO_CTRL_WD=33
  - Status/Cause bit-position constants
- Sub-module cp0_timer: owns Count, Compare, tick and TI, with write ports and a TI output.

Test Plan:
- Reset then read 12/13/9 → Status=0x00400000, Cause=0, Count=0; bus=0; stallreq_for_cp0=0.
- syscall, pc=0xBFC00100, in_delayslot=0 → bus=0x1_BFC00380 that cycle; next cycle EPC=0xBFC00100, ExcCode=8, EXL=1.
- ERET with EPC=0xBFC00100 → bus=0x1_BFC00100; next cycle EXL=0.
- Data AdEL in delay slot, pc=0x80000008, bad_vaddr=0x00000003 → EPC=0x80000004, BD=1, BadVAddr=0x3, ExcCode=4.
- Timer interrupt sequence:
  - Count=0, Compare=10, Status=0x00008001 → stall pulse after each mtc0.
  - TI sets 20 cycles after the Count write.
  - The next inst_valid traps with ExcCode=0.
  - An mtc0 to Compare clears TI.
- excp_ov together with we=1 to Status (wdata=0) → flush asserted; Status.IE unchanged; ExcCode=12; no stall pulse.
